// File: rtl/ctr_regfile_pkg.sv
// Shared types and helpers for the control register file.
package ctr_regfile_pkg;

    // Default geometry of the control register file
    localparam int DEF_DATA_W   = 16;
    localparam int DEF_NUM_REGS = 8;

    // Response FSM: IDLE has nothing pending, RESP holds a response
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    // LSB position of word idx inside a flattened vector of width-bit words
    function automatic int word_lsb(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/ctr_regfile_word.sv
// Single storage word with per-bit masked write and synchronous reset.
module ctr_word #(
    parameter int              DATA_W  = 16,
    parameter logic [DATA_W-1:0] RST_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] wmask,
    output logic [DATA_W-1:0] q
);

    logic [DATA_W-1:0] q_reg;

    // Masked update: only bits with wmask = 1 take the new data
    always_ff @(posedge clk) begin
        if (rst) begin
            q_reg <= RST_VAL;
        end else if (we) begin
            q_reg <= (q_reg & ~wmask) | (wdata & wmask);
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/ctr_regfile.sv
// Control register file: NUM_REGS masked-write words behind a valid/ready
// request/response port, all words driven in parallel on ctr.
// Optional macro CTR_REGFILE_SHADOW_EN: requests address a shadow array and
// ctr follows a live array that copies the whole shadow when commit = 1.
module ctr_regfile
    import ctr_regfile_pkg::*;
#(
    parameter int                DATA_W   = DEF_DATA_W,
    parameter int                NUM_REGS = DEF_NUM_REGS,
    parameter int                ADDR_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1,
    parameter logic [DATA_W-1:0] RST_VAL  = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_we,
    input  logic [ADDR_W-1:0]          req_addr,
    input  logic [DATA_W-1:0]          req_wdata,
    input  logic [DATA_W-1:0]          req_wmask,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [DATA_W-1:0]          rsp_rdata,
    output logic                       rsp_err,
    output logic [NUM_REGS*DATA_W-1:0] ctr,
    input  logic                       commit
);

    // One extra bit so NUM_REGS itself is representable for the range check
    localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W + 1)'(NUM_REGS);

    state_t            state_reg;
    logic [DATA_W-1:0] rsp_rdata_reg;
    logic              rsp_err_reg;

    logic              accept;
    logic              in_range;
    logic              write_acc;
    logic [NUM_REGS-1:0] wr_en;
    logic [DATA_W-1:0] rd_word;

    // Words addressed by requests (the shadow array when shadowing is on)
    logic [DATA_W-1:0] word_q [NUM_REGS];
    // Words driving the datapath
    logic [DATA_W-1:0] live_q [NUM_REGS];

    assign rsp_valid = (state_reg == RESP);
    assign req_ready = !rsp_valid || rsp_ready;
    assign accept    = req_valid && req_ready;
    assign in_range  = ({1'b0, req_addr} < ADDR_LIMIT);
    assign write_acc = accept && req_we && in_range;

    // Read mux over the addressed words; out-of-range addresses read as zero
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (req_addr == ADDR_W'(i)) begin
                rd_word = word_q[i];
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_word
            assign wr_en[gi] = write_acc && (req_addr == ADDR_W'(gi));

            ctr_word #(
                .DATA_W  (DATA_W),
                .RST_VAL (RST_VAL)
            ) u_word (
                .clk   (clk),
                .rst   (rst),
                .we    (wr_en[gi]),
                .wdata (req_wdata),
                .wmask (req_wmask),
                .q     (word_q[gi])
            );

`ifdef CTR_REGFILE_SHADOW_EN
            // Live copy samples the pre-edge shadow, so a same-cycle write waits for the next commit
            ctr_word #(
                .DATA_W  (DATA_W),
                .RST_VAL (RST_VAL)
            ) u_live (
                .clk   (clk),
                .rst   (rst),
                .we    (commit),
                .wdata (word_q[gi]),
                .wmask ({DATA_W{1'b1}}),
                .q     (live_q[gi])
            );
`else
            assign live_q[gi] = word_q[gi];
`endif

            assign ctr[word_lsb(gi, DATA_W) +: DATA_W] = live_q[gi];
        end
    endgenerate

`ifndef CTR_REGFILE_SHADOW_EN
    // commit has no effect without the shadow array
    logic unused_commit;
    assign unused_commit = commit;
`endif

    // Response FSM: a same-cycle consume and accept keeps RESP
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            case (state_reg)
                IDLE:    if (accept) state_reg <= RESP;
                RESP:    if (rsp_ready && !accept) state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Response payload captured at accept and held until consumed
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_rdata_reg <= '0;
            rsp_err_reg   <= 1'b0;
        end else if (accept) begin
            rsp_rdata_reg <= (!req_we && in_range) ? rd_word : '0;
            rsp_err_reg   <= !in_range;
        end
    end

    assign rsp_rdata = rsp_rdata_reg;
    assign rsp_err   = rsp_err_reg;

endmodule

// File: doc/ctr_regfile.md
# ctr_regfile

Parametrised control register file that replaces the single-register control block in the SIMD engine. It holds NUM_REGS control words of DATA_W bits behind an addressed valid/ready request/response port with per-bit write masking and out-of-range error reporting. All words drive the engine datapath in parallel.

## Interface
Parameters:
- DATA_W, 16, width of each control word
- NUM_REGS, 8, number of control words (≥1, need not be a power of two)
- ADDR_W, $clog2(NUM_REGS) (min 1), request address width
- RST_VAL, '0, per-word reset value (DATA_W bits, same for all words)

Ports:
- clk  in  1  sole clock, all logic on posedge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  request can be accepted
- req_we  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  word index
- req_wdata  in  DATA_W  write data
- req_wmask  in  DATA_W  per-bit write enable (1 = bit updated)
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed
- rsp_rdata  out  DATA_W  read data (0 for writes and errors)
- rsp_err  out  1  address ≥ NUM_REGS
- ctr  out  NUM_REGS*DATA_W  live control words, word i at [i*DATA_W +: DATA_W]
- commit  in  1  shadow-to-live copy strobe (used only with CTR_REGFILE_SHADOW_EN)

## Operation
- Handshake: request accepted when req_valid && req_ready. Response held stable until rsp_valid && rsp_ready.
- Two-state FSM: IDLE (no response pending), RESP (rsp_valid = 1).
  - IDLE → RESP on accept.
  - RESP → IDLE on rsp_ready with no new accept.
  - RESP → RESP on rsp_ready with a same-cycle accept.
- req_ready = !rsp_valid || rsp_ready, combinational. This gives back-to-back throughput of one request per cycle.
- Write, in range: word[addr] <= (word & ~wmask) | (wdata & wmask). Response carries rsp_rdata = 0 and rsp_err = 0.
- Read, in range: response carries word[addr] as it was at the accept edge, with rsp_err = 0.
- Out of range (addr ≥ NUM_REGS): storage is untouched. Response carries rsp_err = 1 and rsp_rdata = 0.
- A wmask of all zeros is a legal write. It produces a normal response and changes nothing.
- Reset values: every word = RST_VAL, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, FSM = IDLE.
- Reset mid-transaction drops any pending response with no handshake completion. req_ready is 1 in the cycle after reset deasserts.

## Timing
- Accept at edge T: the write is visible on ctr at T+1, and rsp_valid rises at T+1.
- Read-after-write to the same address, back-to-back: the read accepted at T+1 returns the new value.
- While rsp_ready is held low, rsp_valid, rsp_rdata and rsp_err are held and no new request is accepted.
- ctr is a registered output with no combinational path from the request inputs.

## Configuration
- CTR_REGFILE_SHADOW_EN defined:
  - Writes update a shadow array; reads return shadow contents.
  - ctr drives a separate live array that loads the entire shadow on the edge where commit = 1.
  - commit in the same cycle as a write copies the pre-write shadow. The write reaches ctr only at the next commit.
  - Reset sets both arrays to RST_VAL.
- Not defined: a single array. Writes reach ctr at T+1, and the commit input is ignored.

## Structure
- Shared package ctr_regfile_pkg holds:
  - typedef of the FSM state enum (IDLE, RESP)
  - the default DATA_W and NUM_REGS constants
  - a function for flattened word slicing
- One sub-module, ctr_word, handles a single masked-write storage word (RST_VAL, write enable, mask). It is instantiated NUM_REGS times, and twice as many under CTR_REGFILE_SHADOW_EN.

## Test plan
- Reset, then read all 8 addresses → each response is 0x0000 with rsp_err = 0; ctr is all zeros.
- Write addr 3, data 0xABCD, mask 0xFFFF; then write addr 3, data 0x0000, mask 0x00F0 → ctr word 3 = 0xAB0D; a read of addr 3 returns 0xAB0D.
- NUM_REGS = 6, write addr 7 data 0x1234 → rsp_err = 1, rsp_rdata = 0, all ctr words unchanged. Read addr 6 → rsp_err = 1.
- Back-to-back write addr 1 = 0x5555 then read addr 1 with rsp_ready tied high → reads return 0x5555; req_ready stays 1 and one response is produced per cycle.
- Hold rsp_ready low for 4 cycles after a read of addr 2 = 0x00FF → rsp_valid and rsp_rdata are held at 0x00FF, req_ready = 0, a pending write is not accepted; the write is accepted on the cycle rsp_ready rises.
- Shadow build: write addr 0 = 0x0F0F → ctr word 0 stays 0x0000 until commit pulses, then becomes 0x0F0F. A write plus commit in the same cycle leaves ctr showing the prior shadow value.
